// File: rtl/insn_launcher_pkg.sv
// Shared types for the vector issue stage: insn ids, VFU selector
// and the decoded-instruction bundle passed decoder -> launcher -> VFUs.
package insn_launcher_pkg;

    localparam int unsigned InsnIDNum = 8;
    typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

    localparam int unsigned NrVFU = 3;

    typedef enum logic [1:0] {
        VFU_ALU = 2'd0,
        VFU_MUL = 2'd1,
        VFU_LSU = 2'd2
    } vfu_e;

    typedef struct packed {
        vfu_e       vfu;
        logic [7:0] op;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        insn_id_t   insn_id;
    } issue_req_t;

    // Out-of-range selectors decode to all zeros rather than aliasing a VFU.
    function automatic logic [NrVFU-1:0] vfu_onehot(vfu_e v);
        logic [NrVFU-1:0] oh;
        oh = '0;
        for (int k = 0; k < int'(NrVFU); k++) begin
            oh[k] = (int'(v) == k);
        end
        return oh;
    endfunction

endpackage

// File: rtl/insn_launcher_if.sv
// Issue-side bundle: decoder handshake, scoreboard view, VFU dispatch
// and completion. Signal suffixes are relative to the launcher.
interface insn_launcher_if;
    import insn_launcher_pkg::*;

    logic                  dec_valid_i;
    logic                  dec_ready_o;
    issue_req_t            dec_req_i;
    issue_req_t            issue_req_o;
    logic                  is_issued_o;
    logic                  stall_i;
    logic [NrVFU-1:0]      vfu_valid_o;
    logic [NrVFU-1:0]      vfu_ready_i;
    logic [NrVFU-1:0]      insn_done_i;
    insn_id_t [NrVFU-1:0]  insn_done_id_i;
    logic                  idle_o;

    modport master (
        input  dec_valid_i,
        input  dec_req_i,
        input  stall_i,
        input  vfu_ready_i,
        input  insn_done_i,
        input  insn_done_id_i,
        output dec_ready_o,
        output issue_req_o,
        output is_issued_o,
        output vfu_valid_o,
        output idle_o
    );

    modport slave (
        output dec_valid_i,
        output dec_req_i,
        output stall_i,
        output vfu_ready_i,
        output insn_done_i,
        output insn_done_id_i,
        input  dec_ready_o,
        input  issue_req_o,
        input  is_issued_o,
        input  vfu_valid_o,
        input  idle_o
    );

endinterface

// File: rtl/insn_launcher_id_allocator.sv
// Free-id bitmap: hands out the lowest free insn_id and takes ids
// back from any number of completing VFUs in the same cycle.
module insn_launcher_id_allocator
    import insn_launcher_pkg::*;
#(
    parameter int unsigned NrIds = InsnIDNum
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_i,
    output insn_id_t             alloc_id_o,
    output logic                 any_free_o,
    output logic                 all_free_o,
    output logic [NrIds-1:0]     free_o,
    input  logic [NrVFU-1:0]     rel_valid_i,
    input  insn_id_t [NrVFU-1:0] rel_id_i
);

    logic [NrIds-1:0] free_d, free_q;

    always_comb begin
        alloc_id_o = '0;
        for (int i = int'(NrIds) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_id_o = insn_id_t'(i);
        end
    end

    // Releases are applied after the allocation so both land together.
    always_comb begin
        free_d = free_q;
        if (alloc_i) free_d[alloc_id_o] = 1'b0;
        for (int k = 0; k < int'(NrVFU); k++) begin
            if (rel_valid_i[k]) free_d[rel_id_i[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

    assign any_free_o = |free_q;
    assign all_free_o = &free_q;
    assign free_o     = free_q;

endmodule

// File: rtl/insn_launcher.sv
// Vector issue stage: holds one decoded insn, stamps it with a free
// insn_id and dispatches it to its VFU once the scoreboard allows.
module insn_launcher
    import insn_launcher_pkg::*;
#(
    parameter int unsigned NrIds = InsnIDNum
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    insn_launcher_if.master bus
);

    logic             hold_valid_d, hold_valid_q;
    issue_req_t       hold_req_d, hold_req_q;
    logic [NrVFU-1:0] vfu_hit;
    logic             fire;
    logic             accept;
    logic             dec_ready;
    logic             any_free;
    logic             all_free;
    insn_id_t         alloc_id;
    logic [NrIds-1:0] free;

    insn_launcher_id_allocator #(
        .NrIds (NrIds)
    ) i_ids (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_i     (accept),
        .alloc_id_o  (alloc_id),
        .any_free_o  (any_free),
        .all_free_o  (all_free),
        .free_o      (free),
        .rel_valid_i (bus.insn_done_i),
        .rel_id_i    (bus.insn_done_id_i)
    );

    assign vfu_hit   = vfu_onehot(hold_req_q.vfu);
    assign fire      = hold_valid_q & ~bus.stall_i
                     & |(vfu_hit & bus.vfu_ready_i);
    assign dec_ready = any_free & (~hold_valid_q | fire);
    assign accept    = bus.dec_valid_i & dec_ready;

    // Accept wins over fire so a back-to-back handoff leaves no bubble.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_req_d   = hold_req_q;
        if (fire) hold_valid_d = 1'b0;
        if (accept) begin
            hold_valid_d       = 1'b1;
            hold_req_d         = bus.dec_req_i;
            hold_req_d.insn_id = alloc_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_valid_q <= 1'b0;
            hold_req_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_req_q   <= hold_req_d;
        end
    end

    assign bus.dec_ready_o = dec_ready;
    assign bus.issue_req_o = hold_req_q;
    assign bus.is_issued_o = fire;
    assign bus.vfu_valid_o = {NrVFU{hold_valid_q & ~bus.stall_i}} & vfu_hit;
    assign bus.idle_o      = ~hold_valid_q & all_free;

    a_vfu_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        hold_valid_q |-> (int'(hold_req_q.vfu) < int'(NrVFU)));

    a_dec_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.dec_valid_i && !dec_ready |=> $stable(bus.dec_req_i));

    a_hold_kept: assert property (@(posedge clk_i) disable iff (!rst_ni)
        hold_valid_q && !fire |=> hold_valid_q && $stable(hold_req_q));

    for (genvar k = 0; k < int'(NrVFU); k++) begin : g_rel_chk
        a_rel_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus.insn_done_i[k] |-> !free[bus.insn_done_id_i[k]]);
        for (genvar j = 0; j < k; j++) begin : g_pair
            a_rel_uniq: assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(bus.insn_done_i[j] && bus.insn_done_i[k]
                  && bus.insn_done_id_i[j] == bus.insn_done_id_i[k]));
        end
    end

endmodule

// File: tb/tb_insn_launcher.sv
// Bench for insn_launcher: directed scenarios plus a randomized run,
// all checked against a set/queue based model of issue and id usage.
module tb_insn_launcher;
    import insn_launcher_pkg::*;

    localparam int NrIds = int'(InsnIDNum);

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    insn_launcher_if bus ();

    insn_launcher #(
        .NrIds (NrIds)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int id;
        int vfu;
    } fl_t;

    bit         m_held;
    issue_req_t m_req;
    bit         m_alloc[NrIds];
    fl_t        m_fl[$];
    bit         m_acc;

    logic             o_iss;
    logic             o_rdy;
    insn_id_t         o_id;
    logic [NrVFU-1:0] o_vv;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NrIds; i++) n += int'(m_alloc[i]);
        return n;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < NrIds; i++) if (!m_alloc[i]) return i;
        return -1;
    endfunction

    function automatic issue_req_t mk(input int vfu, input int vd);
        issue_req_t r;
        r = '0;
        r.vfu = vfu_e'(vfu);
        r.vd = 5'(vd);
        r.op = 8'(vd * 3 + 1);
        r.vs1 = 5'(vd + 7);
        r.insn_id = insn_id_t'(vd + 5);
        return r;
    endfunction

    task automatic drive_idle();
        bus.dec_valid_i = 1'b0;
        bus.dec_req_i = '0;
        bus.stall_i = 1'b0;
        bus.vfu_ready_i = '0;
        bus.insn_done_i = '0;
        bus.insn_done_id_i = '0;
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic do_reset();
        rst_ni = 1'b0;
        drive_idle();
        #1;
        check("rst_issued", 64'(bus.is_issued_o), 64'(0));
        check("rst_vfu_valid", 64'(bus.vfu_valid_o), 64'(0));
        check("rst_dec_ready", 64'(bus.dec_ready_o), 64'(1));
        check("rst_idle", 64'(bus.idle_o), 64'(1));
        check("rst_issue_req", 64'(bus.issue_req_o), 64'(0));
        m_held = 1'b0;
        m_req = '0;
        for (int i = 0; i < NrIds; i++) m_alloc[i] = 1'b0;
        m_fl.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic step(input bit dv, input issue_req_t rq, input bit st,
                        input logic [NrVFU-1:0] rdy,
                        input logic [NrVFU-1:0] dn,
                        input insn_id_t [NrVFU-1:0] dn_id);
        bit e_fire, e_rdy, e_idle;
        logic [NrVFU-1:0] e_vv;
        int nid;
        bus.dec_valid_i = dv;
        bus.dec_req_i = rq;
        bus.stall_i = st;
        bus.vfu_ready_i = rdy;
        bus.insn_done_i = dn;
        bus.insn_done_id_i = dn_id;
        #1;
        e_fire = m_held && !st && rdy[int'(m_req.vfu)];
        e_vv = '0;
        if (m_held && !st) e_vv[int'(m_req.vfu)] = 1'b1;
        e_rdy = (m_count() < NrIds) && (!m_held || e_fire);
        e_idle = !m_held && (m_count() == 0);
        o_iss = bus.is_issued_o;
        o_rdy = bus.dec_ready_o;
        o_id = bus.issue_req_o.insn_id;
        o_vv = bus.vfu_valid_o;
        check("is_issued", 64'(o_iss), 64'(e_fire));
        check("vfu_valid", 64'(o_vv), 64'(e_vv));
        check("dec_ready", 64'(o_rdy), 64'(e_rdy));
        check("idle", 64'(bus.idle_o), 64'(e_idle));
        if (m_held) check("issue_req", 64'(bus.issue_req_o), 64'(m_req));
        if (e_fire) begin
            m_fl.push_back('{int'(m_req.insn_id), int'(m_req.vfu)});
            m_held = 1'b0;
        end
        m_acc = dv && e_rdy;
        if (m_acc) begin
            nid = m_lowest();
            m_alloc[nid] = 1'b1;
            m_req = rq;
            m_req.insn_id = insn_id_t'(nid);
            m_held = 1'b1;
        end
        for (int k = 0; k < int'(NrVFU); k++) begin
            if (dn[k]) begin
                m_alloc[int'(dn_id[k])] = 1'b0;
                for (int i = m_fl.size() - 1; i >= 0; i--)
                    if (m_fl[i].id == int'(dn_id[k])) m_fl.delete(i);
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        insn_id_t [NrVFU-1:0] ids;
        issue_req_t pend;
        bit has_pend;
        logic [NrVFU-1:0] dn;
        int cand[$];

        rst_ni = 1'b0;
        drive_idle();
        @(negedge clk_i);
        do_reset();

        // single insn
        step(1, mk(0, 4), 0, '1, '0, '0);
        check("t1_accept", 64'(o_rdy), 64'(1));
        step(0, mk(0, 4), 0, '1, '0, '0);
        check("t1_issued", 64'(o_iss), 64'(1));
        check("t1_id", 64'(o_id), 64'(0));

        // stream of four
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(i < 4, mk(i % 3, 10 + i), 0, '1, '0, '0);
            if (i < 4) check("t2_ready", 64'(o_rdy), 64'(1));
            if (i > 0) begin
                check("t2_issued", 64'(o_iss), 64'(1));
                check("t2_id", 64'(o_id), 64'(i - 1));
            end
        end

        // stall on held insn
        do_reset();
        step(1, mk(1, 5), 0, '1, '0, '0);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(2, 6), 1, '1, '0, '0);
            check("t3_stall_iss", 64'(o_iss), 64'(0));
            check("t3_stall_rdy", 64'(o_rdy), 64'(0));
            check("t3_stall_vv", 64'(o_vv), 64'(0));
        end
        step(1, mk(2, 6), 0, '1, '0, '0);
        check("t3_fire", 64'(o_iss), 64'(1));

        // exhaust ids, then release id 2
        do_reset();
        for (int i = 0; i < NrIds; i++) begin
            step(1, mk(i % 3, i), 0, '1, '0, '0);
            check("t4_ready", 64'(o_rdy), 64'(1));
        end
        step(1, mk(0, 20), 0, '1, '0, '0);
        check("t4_full_rdy", 64'(o_rdy), 64'(0));
        check("t4_last_iss", 64'(o_iss), 64'(1));
        ids = '0;
        ids[1] = insn_id_t'(2);
        step(1, mk(0, 20), 0, '1, 3'b010, ids);
        check("t4_rel_rdy", 64'(o_rdy), 64'(0));
        step(1, mk(0, 20), 0, '1, '0, '0);
        check("t4_reacc", 64'(o_rdy), 64'(1));
        step(0, mk(0, 20), 0, '1, '0, '0);
        check("t4_id", 64'(o_id), 64'(2));

        // two releases in one cycle
        ids = '0;
        ids[0] = insn_id_t'(0);
        ids[1] = insn_id_t'(3);
        step(0, mk(0, 0), 0, '1, 3'b011, ids);
        step(1, mk(1, 21), 0, '1, '0, '0);
        check("t5_acc0", 64'(o_rdy), 64'(1));
        step(1, mk(2, 22), 0, '1, '0, '0);
        check("t5_id0", 64'(o_id), 64'(0));
        check("t5_acc1", 64'(o_rdy), 64'(1));
        step(0, mk(0, 0), 0, '1, '0, '0);
        check("t5_id3", 64'(o_id), 64'(3));

        // reset with state in flight
        do_reset();
        for (int i = 0; i < 5; i++) step(1, mk(0, i), 0, '1, '0, '0);
        step(0, mk(0, 0), 1, '1, '0, '0);
        check("t6_busy", 64'(bus.idle_o), 64'(0));
        do_reset();
        step(1, mk(1, 9), 0, '1, '0, '0);
        step(0, mk(1, 9), 0, '1, '0, '0);
        check("t6_id", 64'(o_id), 64'(0));

        // randomized traffic
        do_reset();
        has_pend = 1'b0;
        pend = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!has_pend && $urandom_range(0, 9) < 7) begin
                pend = mk(int'($urandom_range(0, 2)), int'($urandom_range(0, 31)));
                pend.op = 8'($urandom);
                has_pend = 1'b1;
            end
            dn = '0;
            ids = '0;
            for (int k = 0; k < int'(NrVFU); k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cand.delete();
                    foreach (m_fl[i]) if (m_fl[i].vfu == k) cand.push_back(i);
                    if (cand.size() > 0) begin
                        dn[k] = 1'b1;
                        ids[k] = insn_id_t'(m_fl[cand[$urandom_range(0, cand.size() - 1)]].id);
                    end
                end
            end
            step(has_pend, pend, $urandom_range(0, 3) == 0,
                 NrVFU'($urandom_range(0, 7)), dn, ids);
            if (m_acc) has_pend = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
